// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result stream bundle for cla_pipe_adder (ovf only with CLA_PIPE_OVF_EN)
interface cla_pipe_adder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             BP;
    logic             BG;
`ifdef CLA_PIPE_OVF_EN
    logic             ovf;
`endif

    // master: the environment producing operands and consuming results
    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef CLA_PIPE_OVF_EN
        input  ovf,
`endif
        input  in_ready, out_valid, sum, cout, BP, BG
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef CLA_PIPE_OVF_EN
        output ovf,
`endif
        output in_ready, out_valid, sum, cout, BP, BG
    );
endinterface

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - carry-pipelined 4-bit-group CLA adder; CLA_PIPE_OVF_EN adds signed overflow output
module cla_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_adder_if.slave  bus
);
    localparam int SW = WIDTH / STAGES;
    localparam int NG = SW / 4;

    logic advance;

    // Returns {G, P, cout, sum} of one slice; G is the carry-out assuming ci=0.
    function automatic logic [SW+2:0] cla_slice(input logic [SW-1:0] x, input logic [SW-1:0] y,
                                                input logic ci);
        logic [SW-1:0] gen;
        logic [SW-1:0] prp;
        logic [SW-1:0] s;
        logic [3:0]    g4;
        logic [3:0]    p4;
        logic [3:0]    c4;
        logic          c;
        logic          grp_p;
        logic          grp_g;
        logic          sl_p;
        logic          sl_g;
        gen  = x & y;
        prp  = x ^ y;
        s    = '0;
        c    = ci;
        sl_p = 1'b1;
        sl_g = 1'b0;
        for (int j = 0; j < NG; j++) begin
            g4    = gen[4*j +: 4];
            p4    = prp[4*j +: 4];
            c4[0] = c;
            c4[1] = g4[0] | (p4[0] & c);
            c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & c);
            c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
                  | (p4[2] & p4[1] & p4[0] & c);
            s[4*j +: 4] = p4 ^ c4;
            grp_p = &p4;
            grp_g = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
                  | (p4[3] & p4[2] & p4[1] & g4[0]);
            c     = grp_g | (grp_p & c);
            sl_g  = grp_g | (grp_p & sl_g);
            sl_p  = sl_p & grp_p;
        end
        return {sl_g, sl_p, c, s};
    endfunction

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [SW-1:0]         x_op;
        logic [SW-1:0]         y_op;
        logic                  c_in;
        logic                  v_in;
        logic                  bp_in;
        logic                  bg_in;
        logic [SW-1:0]         s_slice;
        logic                  c_out;
        logic                  p_slice;
        logic                  g_slice;
        logic [(k+1)*SW-1:0]   sum_d;
        logic [(k+1)*SW-1:0]   sum_q;
        logic                  v_q;
        logic                  c_q;
        logic                  bp_q;
        logic                  bg_q;

        if (k == 0) begin : g_first
            assign x_op  = bus.a[SW-1:0];
            assign y_op  = bus.b[SW-1:0];
            assign c_in  = bus.cin;
            assign v_in  = bus.in_valid;
            assign bp_in = 1'b1;
            assign bg_in = 1'b0;
            assign sum_d = s_slice;
        end else begin : g_next
            assign x_op  = g_stage[k-1].g_ops.a_q[SW-1:0];
            assign y_op  = g_stage[k-1].g_ops.b_q[SW-1:0];
            assign c_in  = g_stage[k-1].c_q;
            assign v_in  = g_stage[k-1].v_q;
            assign bp_in = g_stage[k-1].bp_q;
            assign bg_in = g_stage[k-1].bg_q;
            assign sum_d = {s_slice, g_stage[k-1].sum_q};
        end

        always_comb begin
            {g_slice, p_slice, c_out, s_slice} = cla_slice(x_op, y_op, c_in);
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q   <= 1'b0;
                c_q   <= 1'b0;
                bp_q  <= 1'b0;
                bg_q  <= 1'b0;
                sum_q <= '0;
            end else if (advance) begin
                v_q   <= v_in;
                c_q   <= c_out;
                bp_q  <= p_slice & bp_in;
                bg_q  <= g_slice | (p_slice & bg_in);
                sum_q <= sum_d;
            end
        end

        // Skew registers: operand bits still waiting for their slice.
        if (k < STAGES - 1) begin : g_ops
            localparam int HW = WIDTH - (k + 1) * SW;
            logic [HW-1:0] a_d;
            logic [HW-1:0] b_d;
            logic [HW-1:0] a_q;
            logic [HW-1:0] b_q;

            if (k == 0) begin : g_src_in
                assign a_d = bus.a[WIDTH-1:SW];
                assign b_d = bus.b[WIDTH-1:SW];
            end else begin : g_src_prev
                assign a_d = g_stage[k-1].g_ops.a_q[SW +: HW];
                assign b_d = g_stage[k-1].g_ops.b_q[SW +: HW];
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (advance) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end

`ifdef CLA_PIPE_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;
            // carry into the MSB is recovered as sum^a^b at that bit
            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (advance) begin
                    ovf_q <= s_slice[SW-1] ^ x_op[SW-1] ^ y_op[SW-1] ^ c_out;
                end
            end
            assign bus.ovf = ovf_q;
        end
`endif
    end

    assign bus.out_valid = g_stage[STAGES-1].v_q;
    assign bus.sum       = g_stage[STAGES-1].sum_q;
    assign bus.cout      = g_stage[STAGES-1].c_q;
    assign bus.BP        = g_stage[STAGES-1].bp_q;
    assign bus.BG        = g_stage[STAGES-1].bg_q;

    assign advance      = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = advance;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - directed-vector bench for cla_pipe_adder at STAGES 1, 2 and 4
module tb_cla_pipe_adder;
    logic clk;
    logic rst;
    int   passed;
    int   total;

    cla_pipe_adder_if #(.WIDTH(16)) if1 ();
    cla_pipe_adder_if #(.WIDTH(16)) if2 ();
    cla_pipe_adder_if #(.WIDTH(16)) if4 ();

    cla_pipe_adder #(.WIDTH(16), .STAGES(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    cla_pipe_adder #(.WIDTH(16), .STAGES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    cla_pipe_adder #(.WIDTH(16), .STAGES(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1;
        if1.in_valid = 1'b0; if1.out_ready = 1'b0; if1.a = '0; if1.b = '0; if1.cin = 1'b0;
        if2.in_valid = 1'b0; if2.out_ready = 1'b0; if2.a = '0; if2.b = '0; if2.cin = 1'b0;
        if4.in_valid = 1'b0; if4.out_ready = 1'b0; if4.a = '0; if4.b = '0; if4.cin = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        total++;
        if ({if2.out_valid, if2.sum, if2.cout, if2.BP, if2.BG} !== 20'h0)
            $display("FAIL reset_outputs: got %h expected 00000",
                     {if2.out_valid, if2.sum, if2.cout, if2.BP, if2.BG});
        else passed++;
        total++;
        if (if2.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", if2.in_ready);
        else passed++;
`ifdef CLA_PIPE_OVF_EN
        total++;
        if (if2.ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", if2.ovf);
        else passed++;
`endif
    endtask

    // Single op into the idle STAGES=2 pipe with out_ready held high.
    task automatic run_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic [15:0] es, input logic ec,
                          input logic ebp, input logic ebg);
        int lat;
        if2.a = a; if2.b = b; if2.cin = ci;
        if2.in_valid = 1'b1; if2.out_ready = 1'b1;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        lat = 1;
        while (!if2.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat !== 2) $display("FAIL %s_latency: got %0d expected 2", nm, lat);
        else passed++;
        total++;
        if ({if2.sum, if2.cout, if2.BP, if2.BG} !== {es, ec, ebp, ebg})
            $display("FAIL %s_result: got sum=%h cout=%b BP=%b BG=%b expected sum=%h cout=%b BP=%b BG=%b",
                     nm, if2.sum, if2.cout, if2.BP, if2.BG, es, ec, ebp, ebg);
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors();
        run_op("ffff_p_1",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("aaaa_p_5555", 16'hAAAA, 16'h5555, 1'b0, 16'hFFFF, 1'b0, 1'b1, 1'b0);
        run_op("aaaa_p_5555_c", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("1234_p_5678_c", 16'h1234, 16'h5678, 1'b1, 16'h68AD, 1'b0, 1'b0, 1'b0);
        run_op("8000_p_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("ffff_p_0_c", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [15:0] va [8];
        logic [15:0] vb [8];
        logic        vc [8];
        logic [16:0] ve [8];
        logic        pat [8];
        int          sent;
        int          got;
        logic        stall_prev;
        logic [16:0] held;
        logic        in_x;
        logic        out_x;
        va = '{16'hFFFF, 16'hAAAA, 16'hAAAA, 16'h1234, 16'h8000, 16'h0F0F, 16'h7FFF, 16'h0000};
        vb = '{16'h0001, 16'h5555, 16'h5555, 16'h5678, 16'h8000, 16'hF0F1, 16'h0001, 16'h0000};
        vc = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        ve = '{17'h1_0000, 17'h0_FFFF, 17'h1_0000, 17'h0_68AD, 17'h1_0000, 17'h1_0000,
               17'h0_8001, 17'h0_0001};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        sent = 0; got = 0; stall_prev = 1'b0; held = '0;
        for (int c = 0; c < 60 && got < 8; c++) begin
            if2.out_ready = pat[c % 8];
            if2.in_valid  = (sent < 8);
            if2.a   = va[sent % 8];
            if2.b   = vb[sent % 8];
            if2.cin = vc[sent % 8];
            @(negedge clk);
            total++;
            if (if2.in_ready !== !(if2.out_valid && !if2.out_ready))
                $display("FAIL b2b_in_ready: got %b expected %b at cycle %0d",
                         if2.in_ready, !(if2.out_valid && !if2.out_ready), c);
            else passed++;
            if (stall_prev) begin
                total++;
                if ({if2.out_valid, if2.cout, if2.sum} !== {1'b1, held})
                    $display("FAIL b2b_stall_hold: got %h expected %h", {if2.out_valid, if2.cout, if2.sum},
                             {1'b1, held});
                else passed++;
            end
            in_x  = if2.in_valid && if2.in_ready;
            out_x = if2.out_valid && if2.out_ready;
            if (out_x) begin
                total++;
                if ({if2.cout, if2.sum} !== ve[got])
                    $display("FAIL b2b_result%0d: got %h expected %h", got, {if2.cout, if2.sum}, ve[got]);
                else passed++;
                got++;
            end
            stall_prev = if2.out_valid && !if2.out_ready;
            held = {if2.cout, if2.sum};
            if (in_x) sent++;
            @(posedge clk); #1;
        end
        if2.in_valid = 1'b0;
        total++;
        if (got !== 8) $display("FAIL b2b_count: got %0d expected 8", got);
        else passed++;
    endtask

    task automatic test_reset_midstream();
        if2.out_ready = 1'b0;
        if2.in_valid = 1'b1; if2.a = 16'h1111; if2.b = 16'h2222; if2.cin = 1'b0;
        @(posedge clk); #1;
        if2.a = 16'h3333; if2.b = 16'h4444;
        @(posedge clk); #1;
        if2.in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        if2.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            total++;
            if (if2.out_valid !== 1'b0) $display("FAIL midrst_drop%0d: got %b expected 0", c, if2.out_valid);
            else passed++;
            @(posedge clk); #1;
        end
        run_op("after_rst", 16'h1234, 16'h5678, 1'b1, 16'h68AD, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic stage_op(input string nm, input logic [15:0] a, input logic [15:0] b,
                            input logic ci, input logic [16:0] exp);
        int          l1;
        int          l4;
        logic [16:0] r1;
        logic [16:0] r4;
        l1 = 0; l4 = 0; r1 = '0; r4 = '0;
        if1.a = a; if1.b = b; if1.cin = ci; if1.in_valid = 1'b1; if1.out_ready = 1'b1;
        if4.a = a; if4.b = b; if4.cin = ci; if4.in_valid = 1'b1; if4.out_ready = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if1.in_valid = 1'b0;
            if4.in_valid = 1'b0;
            if (if1.out_valid && l1 == 0) begin l1 = c; r1 = {if1.cout, if1.sum}; end
            if (if4.out_valid && l4 == 0) begin l4 = c; r4 = {if4.cout, if4.sum}; end
        end
        total++;
        if (l1 !== 1 || r1 !== exp)
            $display("FAIL %s_s1: got lat=%0d res=%h expected lat=1 res=%h", nm, l1, r1, exp);
        else passed++;
        total++;
        if (l4 !== 4 || r4 !== exp)
            $display("FAIL %s_s4: got lat=%0d res=%h expected lat=4 res=%h", nm, l4, r4, exp);
        else passed++;
    endtask

    task automatic test_stages();
        stage_op("st_ffff_p_1",  16'hFFFF, 16'h0001, 1'b0, 17'h1_0000);
        stage_op("st_aaaa_5555", 16'hAAAA, 16'h5555, 1'b0, 17'h0_FFFF);
        stage_op("st_aaaa_5555c", 16'hAAAA, 16'h5555, 1'b1, 17'h1_0000);
        stage_op("st_1234_5678c", 16'h1234, 16'h5678, 1'b1, 17'h0_68AD);
        stage_op("st_8000_8000", 16'h8000, 16'h8000, 1'b0, 17'h1_0000);
    endtask

`ifdef CLA_PIPE_OVF_EN
    task automatic test_ovf();
        run_op("ovf_7fff_p_1", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0);
        total++;
        if (if2.ovf !== 1'b1) $display("FAIL ovf_set: got %b expected 1", if2.ovf);
        else passed++;
        run_op("ovf_ffff_p_1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        total++;
        if (if2.ovf !== 1'b0) $display("FAIL ovf_clear: got %b expected 0", if2.ovf);
        else passed++;
    endtask
`endif

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_vectors();
        test_back_to_back();
        test_reset_midstream();
        test_stages();
`ifdef CLA_PIPE_OVF_EN
        test_ovf();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
